// File: rtl/dm_pkg.sv
// dm_pkg: data-memory parameters shared by the store buffer and the memory.
//   DM_ADDR_W  byte address width of the data memory port
//   DM_WORDS   number of 32-bit words in the data memory
//   sb_entry_t one buffered store {word address, data, pc}
//   dm_word_idx() word index of a byte address inside the memory array
package dm_pkg;

  localparam int DM_ADDR_W  = 16;
  localparam int DM_WORDS   = 3072;
  localparam int SB_WADDR_W = DM_ADDR_W - 2;

  typedef struct packed {
    logic [SB_WADDR_W-1:0] waddr;
    logic [31:0]           data;
    logic [31:0]           pc;
  } sb_entry_t;

  function automatic logic [11:0] dm_word_idx(input logic [DM_ADDR_W-1:0] addr);
    return addr[13:2];
  endfunction

endpackage

// File: rtl/store_buffer_match.sv
// store_buffer_match: load-address lookup across the buffered entries.
// Ports:
//   waddr_arr  in  word address of every slot
//   valid      in  occupied-slot mask
//   head       in  head pointer (oldest entry)
//   ld_waddr   in  word address of the current load
//   hit        out any occupied slot matches
//   idx        out slot index of the youngest match (head when no match)
module store_buffer_match
  import dm_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 14
) (
  input  logic [AW-1:0]            waddr_arr [DEPTH],
  input  logic [DEPTH-1:0]         valid,
  input  logic [$clog2(DEPTH)-1:0] head,
  input  logic [AW-1:0]            ld_waddr,
  output logic                     hit,
  output logic [$clog2(DEPTH)-1:0] idx
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] pos;

  // Walk from the oldest entry toward the tail; a later match overrides an
  // earlier one, so the surviving index is the youngest matching store.
  always_comb begin
    hit = 1'b0;
    idx = head;
    pos = head;
    for (int off = 0; off < DEPTH; off++) begin
      pos = head + PW'(off);
      if (valid[pos] && (waddr_arr[pos] == ld_waddr)) begin
        hit = 1'b1;
        idx = pos;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO between execute and the data memory write
// port, with a load-address check so loads never see stale memory data.
// Build option: STORE_BUFFER_FWD_EN -- when defined, ld_data returns the
// youngest matching store; otherwise ld_data is 0 and ld_hit is a conflict
// flag the CPU stalls on.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   st_valid/st_ready           store handshake
//   st_addr, st_data, st_pc     store byte address (bits [1:0] ignored), word, pc
//   ld_addr                     load byte address (bits [1:0] ignored)
//   ld_hit, ld_data             load match flag and forwarded data
//   drain_hold                  blocks retirement this cycle
//   dm_we, dm_addr, dm_wd, dm_pc  data memory write port (head entry)
//   count, empty, full          occupancy
module store_buffer
  import dm_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = DM_ADDR_W,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [ADDR_W-1:0]        st_addr,
  input  logic [DATA_W-1:0]        st_data,
  input  logic [31:0]              st_pc,
  input  logic [ADDR_W-1:0]        ld_addr,
  output logic                     ld_hit,
  output logic [DATA_W-1:0]        ld_data,
  input  logic                     drain_hold,
  output logic                     dm_we,
  output logic [ADDR_W-1:0]        dm_addr,
  output logic [DATA_W-1:0]        dm_wd,
  output logic [31:0]              dm_pc,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int AW = ADDR_W - 2;

  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;

  logic [AW-1:0]     waddr_q [DEPTH];
  logic [DATA_W-1:0] data_q  [DEPTH];
  logic [31:0]       pc_q    [DEPTH];

  logic              push;
  logic              pop;
  logic [DEPTH-1:0]  valid;
  logic [PW-1:0]     offset;
  logic              match_hit;
  logic [PW-1:0]     match_idx;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign count    = count_q;
  assign st_ready = !full;

  assign push  = st_valid && !full;
  assign dm_we = !empty && !drain_hold;
  assign pop   = dm_we;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) tail_d = tail_q + 1'b1;
    if (pop)  head_d = head_q + 1'b1;
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Slot storage needs no reset: nothing reads a slot outside the valid window.
  always_ff @(posedge clk) begin
    if (push) begin
      waddr_q[tail_q] <= st_addr[ADDR_W-1:2];
      data_q[tail_q]  <= st_data;
      pc_q[tail_q]    <= st_pc;
    end
  end

  // A slot is occupied when its distance from the head is below count.
  always_comb begin
    valid  = '0;
    offset = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset   = PW'(i) - head_q;
      valid[i] = ({1'b0, offset} < count_q);
    end
  end

  always_comb begin
    dm_addr = '0;
    dm_wd   = '0;
    dm_pc   = '0;
    if (!empty) begin
      dm_addr = {waddr_q[head_q], 2'b00};
      dm_wd   = data_q[head_q];
      dm_pc   = pc_q[head_q];
    end
  end

  store_buffer_match #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_match (
    .waddr_arr (waddr_q),
    .valid     (valid),
    .head      (head_q),
    .ld_waddr  (ld_addr[ADDR_W-1:2]),
    .hit       (match_hit),
    .idx       (match_idx)
  );

  assign ld_hit = match_hit;

`ifdef STORE_BUFFER_FWD_EN
  assign ld_data = match_hit ? data_q[match_idx] : '0;
`else
  assign ld_data = '0;
  logic unused_idx;
  assign unused_idx = ^match_idx;
`endif

  logic unused_low_bits;
  assign unused_low_bits = ^{st_addr[1:0], ld_addr[1:0]};

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset && dm_we)
      $display("@%08h: *%08h <= %08h", dm_pc, 32'(dm_addr), dm_wd);
  end
`endif

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic        st_ready;
  logic [15:0] st_addr;
  logic [31:0] st_data;
  logic [31:0] st_pc;
  logic [15:0] ld_addr;
  logic        ld_hit;
  logic [31:0] ld_data;
  logic        drain_hold;
  logic        dm_we;
  logic [15:0] dm_addr;
  logic [31:0] dm_wd;
  logic [31:0] dm_pc;
  logic [2:0]  count;
  logic        empty;
  logic        full;

`ifdef STORE_BUFFER_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  int passed = 0;
  int total  = 0;

  store_buffer dut (
    .clk        (clk),
    .reset      (reset),
    .st_valid   (st_valid),
    .st_ready   (st_ready),
    .st_addr    (st_addr),
    .st_data    (st_data),
    .st_pc      (st_pc),
    .ld_addr    (ld_addr),
    .ld_hit     (ld_hit),
    .ld_data    (ld_data),
    .drain_hold (drain_hold),
    .dm_we      (dm_we),
    .dm_addr    (dm_addr),
    .dm_wd      (dm_wd),
    .dm_pc      (dm_pc),
    .count      (count),
    .empty      (empty),
    .full       (full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sv;
    logic [15:0] sa;
    logic [31:0] sd;
    logic [31:0] sp;
    logic        hold;
    logic [15:0] la;
    logic [2:0]  ecount;
    logic        ewe;
    logic [15:0] eaddr;
    logic [31:0] ewd;
    logic [31:0] epc;
    logic        ehit;
    logic [31:0] eld;
  } vec_t;

  vec_t vecs[10];

  function automatic vec_t mk(logic sv, logic [15:0] sa, logic [31:0] sd, logic [31:0] sp,
                              logic hold, logic [15:0] la, logic [2:0] ecount, logic ewe,
                              logic [15:0] eaddr, logic [31:0] ewd, logic [31:0] epc,
                              logic ehit, logic [31:0] eld);
    vec_t v;
    v.sv = sv; v.sa = sa; v.sd = sd; v.sp = sp; v.hold = hold; v.la = la;
    v.ecount = ecount; v.ewe = ewe; v.eaddr = eaddr; v.ewd = ewd; v.epc = epc;
    v.ehit = ehit; v.eld = eld;
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    st_valid = 1'b0; st_addr = '0; st_data = '0; st_pc = '0;
  endtask

  task automatic push_hold(logic [15:0] a, logic [31:0] d, logic [31:0] p);
    drain_hold = 1'b1;
    st_valid = 1'b1; st_addr = a; st_data = d; st_pc = p;
    step();
  endtask

  logic [31:0] got[$];
  logic [31:0] expq[$];

  task automatic drain_collect(string name);
    int c;
    c = 0;
    idle_inputs();
    drain_hold = 1'b0;
    #1;
    while (!empty && c < 20) begin
      if (dm_we) got.push_back(dm_wd);
      step();
      c++;
    end
    chk({name, "_drained"}, 64'(empty), 64'(1));
    chk({name, "_n"}, 64'(got.size()), 64'(expq.size()));
    for (int i = 0; i < expq.size(); i++)
      chk($sformatf("%s_data%0d", name, i), 64'(i < got.size() ? got[i] : 32'hDEAD_DEAD), 64'(expq[i]));
  endtask

  initial begin
    int pulses;
    reset = 1'b1; drain_hold = 1'b0; ld_addr = '0;
    idle_inputs();
    step(); step();
    reset = 1'b0;
    #1;
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_empty", 64'(empty), 64'(1));
    chk("rst_full",  64'(full),  64'(0));
    chk("rst_ready", 64'(st_ready), 64'(1));
    chk("rst_we",    64'(dm_we), 64'(0));
    chk("rst_hit",   64'(ld_hit), 64'(0));
    chk("rst_data",  64'({dm_addr, dm_wd, dm_pc, ld_data} != '0), 64'(0));

    vecs[0] = mk(0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0);
    vecs[1] = mk(1, 16'h0010, 32'h12345678, 32'h3000, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0);
    vecs[2] = mk(0, 16'h0000, 0, 0, 0, 16'h0012, 1, 1, 16'h0010, 32'h12345678, 32'h3000, 1, 32'h12345678);
    vecs[3] = mk(0, 16'h0000, 0, 0, 1, 16'h0022, 0, 0, 16'h0000, 0, 0, 0, 0);
    vecs[4] = mk(1, 16'h0023, 32'hAAAA0000, 32'h3004, 1, 16'h0022, 0, 0, 16'h0000, 0, 0, 0, 0);
    vecs[5] = mk(1, 16'h0020, 32'hBBBB0000, 32'h3008, 1, 16'h0022, 1, 0, 16'h0020, 32'hAAAA0000, 32'h3004, 1, 32'hAAAA0000);
    vecs[6] = mk(0, 16'h0000, 0, 0, 1, 16'h0022, 2, 0, 16'h0020, 32'hAAAA0000, 32'h3004, 1, 32'hBBBB0000);
    vecs[7] = mk(0, 16'h0000, 0, 0, 0, 16'h0022, 2, 1, 16'h0020, 32'hAAAA0000, 32'h3004, 1, 32'hBBBB0000);
    vecs[8] = mk(0, 16'h0000, 0, 0, 0, 16'h0020, 1, 1, 16'h0020, 32'hBBBB0000, 32'h3008, 1, 32'hBBBB0000);
    vecs[9] = mk(0, 16'h0000, 0, 0, 0, 16'h0020, 0, 0, 16'h0000, 0, 0, 0, 0);

    for (int i = 0; i < 10; i++) begin
      st_valid = vecs[i].sv; st_addr = vecs[i].sa; st_data = vecs[i].sd; st_pc = vecs[i].sp;
      drain_hold = vecs[i].hold; ld_addr = vecs[i].la;
      #1;
      chk($sformatf("v%0d_count", i), 64'(count), 64'(vecs[i].ecount));
      chk($sformatf("v%0d_ready", i), 64'(st_ready), 64'(1));
      chk($sformatf("v%0d_we", i), 64'(dm_we), 64'(vecs[i].ewe));
      chk($sformatf("v%0d_addr", i), 64'(dm_addr), 64'(vecs[i].eaddr));
      chk($sformatf("v%0d_wd", i), 64'(dm_wd), 64'(vecs[i].ewd));
      chk($sformatf("v%0d_pc", i), 64'(dm_pc), 64'(vecs[i].epc));
      chk($sformatf("v%0d_hit", i), 64'(ld_hit), 64'(vecs[i].ehit));
      chk($sformatf("v%0d_lddata", i), 64'(ld_data), 64'(FWD ? vecs[i].eld : 32'h0));
      step();
    end
    ld_addr = 16'hFFFC;

    // Five stores under hold: the fifth is refused, then four retire in order.
    got.delete(); expq.delete();
    for (int i = 0; i < 5; i++) begin
      drain_hold = 1'b1; st_valid = 1'b1;
      st_addr = 16'h0100 + 16'(4 * i); st_data = 32'hD000_0000 + i; st_pc = 32'h4000 + 4 * i;
      #1;
      chk($sformatf("hold_ready%0d", i), 64'(st_ready), 64'(i < 4));
      chk($sformatf("hold_full%0d", i), 64'(full), 64'(i == 4));
      if (i < 4) expq.push_back(32'hD000_0000 + i);
      step();
    end
    chk("hold_count", 64'(count), 64'(4));
    drain_collect("hold");

    // Full buffer, hold released with a store waiting.
    got.delete(); expq.delete();
    for (int i = 0; i < 4; i++) push_hold(16'h0200 + 16'(4 * i), 32'hF000_0000 + i, 32'h5000 + 4 * i);
    drain_hold = 1'b0; st_valid = 1'b1; st_addr = 16'h0300; st_data = 32'hE000_000E; st_pc = 32'h6000;
    #1;
    chk("fullpop_ready", 64'(st_ready), 64'(0));
    chk("fullpop_we", 64'(dm_we), 64'(1));
    chk("fullpop_wd", 64'(dm_wd), 64'(32'hF000_0000));
    step();
    chk("fullpop_count3", 64'(count), 64'(3));
    chk("fullpop_ready2", 64'(st_ready), 64'(1));
    step();
    chk("fullpop_count_pushpop", 64'(count), 64'(3));
    expq.push_back(32'hF000_0002); expq.push_back(32'hF000_0003); expq.push_back(32'hE000_000E);
    drain_collect("fullpop");

    // Alternating push/pop through more than two wraps of the pointers.
    got.delete(); expq.delete();
    for (int i = 0; i < 10; i++) begin
      drain_hold = 1'b0; st_valid = 1'b1;
      st_addr = 16'h0400 + 16'(4 * i); st_data = 32'hC0DE_0000 + i; st_pc = 32'h7000 + 4 * i;
      expq.push_back(32'hC0DE_0000 + i);
      #1;
      chk($sformatf("wrap_count%0d", i), 64'(count), 64'(i == 0 ? 0 : 1));
      if (dm_we) got.push_back(dm_wd);
      step();
    end
    drain_collect("wrap");

    // Reset with three stores pending.
    for (int i = 0; i < 3; i++) push_hold(16'h0500 + 16'(4 * i), 32'h9000_0000 + i, 32'h8000 + 4 * i);
    idle_inputs();
    #1;
    chk("rstmid_count_before", 64'(count), 64'(3));
    reset = 1'b1;
    step();
    reset = 1'b0; drain_hold = 1'b0;
    #1;
    chk("rstmid_count", 64'(count), 64'(0));
    chk("rstmid_empty", 64'(empty), 64'(1));
    pulses = 0;
    for (int c = 0; c < 5; c++) begin
      if (dm_we) pulses++;
      step();
    end
    chk("rstmid_pulses", 64'(pulses), 64'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
